// File: rtl/crc_serial_engine.sv
// crc_serial_engine: parametrised serial CRC generator/checker (optional CRC_ERR_CNT_EN adds err_cnt)
module crc_serial_engine #(
  parameter int CRC_W = 5,
  parameter logic [CRC_W-1:0] POLY = 5'b00101,
  parameter logic [CRC_W-1:0] RESIDUAL = 5'b01100,
  parameter int DATA_LEN = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic crc_start,
  input  logic mode,
  input  logic s_in,
  input  logic bit_valid,
  input  logic out_ready,
  input  logic crc_ack,
  output logic crc_out,
  output logic crc_out_valid,
  output logic busy,
  output logic crc_done,
  output logic crc_ok
`ifdef CRC_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);
  localparam int CW = $clog2(DATA_LEN + CRC_W + 1);
  typedef enum logic [1:0] {IDLE, DATA, EMIT, DONE} state_t;
  state_t state, state_n;
  logic [CRC_W-1:0] r, r_next, sh;
  logic [CW-1:0] cnt;
  logic mode_q, fin, emit_last;
  assign r_next = {r[CRC_W-2:0], 1'b0} ^ ((r[CRC_W-1] ^ s_in) ? POLY : '0);
  assign fin = bit_valid && (cnt == (mode_q ? CW'(DATA_LEN + CRC_W - 1) : CW'(DATA_LEN - 1)));
  assign emit_last = out_ready && (cnt == CW'(CRC_W - 1));
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // next-state: payload end goes to EMIT (generate) or DONE (check)
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = crc_start ? DATA : IDLE;
      DATA: state_n = fin ? (mode_q ? DONE : EMIT) : DATA;
      EMIT: state_n = emit_last ? DONE : EMIT;
      DONE: state_n = crc_ack ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  // outputs decoded from the registered state; crc_out forced low outside EMIT
  always_comb begin
    crc_out_valid = state == EMIT;
    crc_out = (state == EMIT) & sh[CRC_W-1];
    busy = state != IDLE;
    crc_done = state == DONE;
  end
  // datapath: CRC register, shared payload/emit counter, output shifter, result flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r <= '1;
      cnt <= '0;
      mode_q <= 1'b0;
      sh <= '0;
      crc_ok <= 1'b0;
    end else case (state)
      IDLE: if (crc_start) begin
        r <= '1;
        cnt <= '0;
        mode_q <= mode;
        crc_ok <= 1'b0;
      end
      DATA: if (bit_valid) begin
        r <= r_next;
        cnt <= (fin && !mode_q) ? '0 : cnt + 1'b1;
        if (fin && !mode_q) sh <= ~r_next;
        if (fin && mode_q) crc_ok <= r_next == RESIDUAL;
      end
      EMIT: if (out_ready) begin
        sh <= {sh[CRC_W-2:0], 1'b0};
        cnt <= cnt + 1'b1;
      end
      DONE: if (crc_ack) crc_ok <= 1'b0;
      default: ;
    endcase
`ifdef CRC_ERR_CNT_EN
  // saturating count of failed checks, cleared only by reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_cnt <= '0;
    else if (state == DATA && fin && mode_q && r_next != RESIDUAL && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_crc_serial_engine.sv
// tb_crc_serial_engine: random and directed checks of CRC5 and CRC16 engines against a polynomial-division model
module tb_crc_serial_engine;
  localparam int W5 = 5, N5 = 11, W16 = 16, N16 = 16;
  localparam logic [31:0] P5 = 32'h05, R5 = 32'h0C, P16 = 32'h8005, R16 = 32'h800D;
  logic clk = 0, rst_n = 1, start5 = 0, start16 = 0, mode = 0, s_in = 0, bit_valid = 0, out_ready = 0, crc_ack = 0;
  logic out5, ov5, busy5, done5, ok5, out16, ov16, busy16, done16, ok16;
  logic co, cv, cb, cd, ck;
  int sel = 0, checks = 0, failures = 0, exp_err5 = 0, exp_err16 = 0;
`ifdef CRC_ERR_CNT_EN
  logic [7:0] err5, err16;
`endif
  assign co = sel != 0 ? out16 : out5;
  assign cv = sel != 0 ? ov16 : ov5;
  assign cb = sel != 0 ? busy16 : busy5;
  assign cd = sel != 0 ? done16 : done5;
  assign ck = sel != 0 ? ok16 : ok5;
  crc_serial_engine u5 (
    .clk(clk), .rst_n(rst_n), .crc_start(start5), .mode(mode), .s_in(s_in), .bit_valid(bit_valid),
    .out_ready(out_ready), .crc_ack(crc_ack), .crc_out(out5), .crc_out_valid(ov5), .busy(busy5),
    .crc_done(done5), .crc_ok(ok5)
`ifdef CRC_ERR_CNT_EN
    , .err_cnt(err5)
`endif
  );
  crc_serial_engine #(.CRC_W(16), .POLY(16'h8005), .RESIDUAL(16'h800D), .DATA_LEN(16)) u16 (
    .clk(clk), .rst_n(rst_n), .crc_start(start16), .mode(mode), .s_in(s_in), .bit_valid(bit_valid),
    .out_ready(out_ready), .crc_ack(crc_ack), .crc_out(out16), .crc_out_valid(ov16), .busy(busy16),
    .crc_done(done16), .crc_ok(ok16)
`ifdef CRC_ERR_CNT_EN
    , .err_cnt(err16)
`endif
  );
  always #5 clk = ~clk;
  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Register value after shifting m in from all-ones = remainder of (m with first w bits inverted) * x^w mod G
  function automatic logic [31:0] crc_reg(input bit m[$], input int w, input logic [31:0] poly);
    bit a[$];
    logic [31:0] res = '0;
    a = m;
    for (int i = 0; i < w; i++) a[i] = ~a[i];
    for (int i = 0; i < w; i++) a.push_back(1'b0);
    for (int i = 0; i + w < a.size(); i++)
      if (a[i]) begin
        a[i] = 1'b0;
        for (int j = 1; j <= w; j++) a[i+j] = a[i+j] ^ poly[w-j];
      end
    for (int i = 0; i < w; i++) res = {res[30:0], a[a.size()-w+i]};
    return res;
  endfunction
  function automatic logic [31:0] pack(input bit q[$]);
    logic [31:0] v = '0;
    foreach (q[i]) v = {v[30:0], q[i]};
    return v;
  endfunction
  function automatic logic [31:0] exp_crc(input bit q[$], input int s);
    int w = s != 0 ? W16 : W5;
    return ~crc_reg(q, w, s != 0 ? P16 : P5) & ((32'h1 << w) - 1);
  endfunction
  function automatic bit exp_ok(input bit q[$], input int s);
    return crc_reg(q, s != 0 ? W16 : W5, s != 0 ? P16 : P5) == (s != 0 ? R16 : R5);
  endfunction
  task automatic set_start(input int s, input logic v);
    if (s != 0) start16 = v;
    else start5 = v;
  endtask
  task automatic run_pkt(input int s, input bit md, input bit bits[$], input bit gaps, input bit bp,
                         input bit start_mid, input bit ack_start, output bit em[$], output bit ok);
    int w = s != 0 ? W16 : W5;
    int tmo;
    bit held = 0;
    logic prev;
    em = {};
    sel = s;
    @(negedge clk);
    mode = md;
    set_start(s, 1);
    @(negedge clk);
    set_start(s, 0);
    mode = ~md;
    chk("busy_after_start", cb, 1);
    foreach (bits[i]) begin
      while (gaps && $urandom_range(0, 2) == 0) begin
        bit_valid = 0;
        s_in = 1'($urandom);
        @(negedge clk);
      end
      s_in = bits[i];
      bit_valid = 1;
      if (start_mid && i == 2) set_start(s, 1);
      @(negedge clk);
      set_start(s, 0);
    end
    bit_valid = 0;
    if (!md) begin
      chk("emit_latency", cv, 1);
      tmo = 0;
      while (em.size() < w && tmo < 200) begin
        if (cv) begin
          if (bp && !held && em.size() == 2) begin
            held = 1;
            prev = co;
            out_ready = 0;
            repeat (4) begin
              bit_valid = 1'($urandom);
              s_in = 1'($urandom);
              @(negedge clk);
              chk("hold_bit", co, prev);
              chk("hold_valid", cv, 1);
            end
            bit_valid = 0;
          end
          out_ready = 1;
          em.push_back(co);
        end
        @(negedge clk);
        tmo++;
      end
      out_ready = 0;
      chk("emit_count", em.size(), w);
      chk("emit_valid_drop", cv, 0);
    end else chk("check_latency", cd, 1);
    tmo = 0;
    while (!cd && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    chk("done", cd, 1);
    ok = ck;
    if (md && !exp_ok(bits, s)) begin
      if (s != 0) exp_err16 = exp_err16 < 255 ? exp_err16 + 1 : 255;
      else exp_err5 = exp_err5 < 255 ? exp_err5 + 1 : 255;
    end
    crc_ack = 1;
    if (ack_start) set_start(s, 1);
    @(negedge clk);
    crc_ack = 0;
    set_start(s, 0);
    chk("ack_busy", cb, 0);
    chk("ack_done", cd, 0);
    chk("ack_ok", ck, 0);
    if (ack_start) begin
      @(negedge clk);
      chk("ack_start_ignored", cb, 0);
    end
  endtask
  task automatic check_err();
`ifdef CRC_ERR_CNT_EN
    chk("err_cnt5", err5, exp_err5);
    chk("err_cnt16", err16, exp_err16);
`endif
  endtask
  // Generate, then check the payload with the emitted CRC, then check with one corrupted bit
  task automatic round_trip(input int s, input bit pl[$], input bit gaps, input bit bp, input bit smid, input bit ackst);
    bit em[$], full[$];
    bit ok;
    int idx;
    run_pkt(s, 0, pl, gaps, bp, smid, ackst, em, ok);
    chk("gen_crc", pack(em), exp_crc(pl, s));
    chk("gen_ok", ok, 0);
    full = pl;
    foreach (em[i]) full.push_back(em[i]);
    run_pkt(s, 1, full, gaps, 0, smid, 0, em, ok);
    chk("chk_good", ok, 1);
    idx = $urandom_range(0, full.size() - 1);
    full[idx] = ~full[idx];
    run_pkt(s, 1, full, gaps, 0, 0, 0, em, ok);
    chk("chk_bad", ok, 0);
    chk("chk_bad_model", ok, exp_ok(full, s));
    check_err();
  endtask
  initial begin
    bit pl[$], full[$], em[$];
    bit ok;
    #2 rst_n = 0;
    #1;
    chk("rst_out", {out5, ov5, busy5, done5, ok5, out16, ov16, busy16, done16, ok16}, 0);
    check_err();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("idle_busy", {busy5, busy16}, 0);
    pl = {};
    for (int i = 0; i < N5; i++) pl.push_back(1'b0);
    run_pkt(0, 0, pl, 0, 0, 0, 0, em, ok);
    chk("gen_zero_crc", pack(em), 32'h08);
    chk("gen_zero_model", pack(em), exp_crc(pl, 0));
    chk("gen_zero_ok", ok, 0);
    full = pl;
    full.push_back(0); full.push_back(1); full.push_back(0); full.push_back(0); full.push_back(0);
    run_pkt(0, 1, full, 0, 0, 0, 0, em, ok);
    chk("chk_zero_ok", ok, 1);
    full[3] = 1'b1;
    run_pkt(0, 1, full, 0, 0, 0, 0, em, ok);
    chk("chk_flip3_ok", ok, 0);
    check_err();
    pl = {};
    for (int i = 0; i < N5; i++) pl.push_back(1'($urandom));
    round_trip(0, pl, 1, 1, 1, 1);
    pl = {};
    for (int i = 0; i < N16; i++) pl.push_back(1'(16'hA5C3 >> (15 - i)));
    round_trip(1, pl, 0, 0, 0, 0);
    for (int t = 0; t < 12; t++) begin
      pl = {};
      for (int i = 0; i < (t % 2 != 0 ? N16 : N5); i++) pl.push_back(1'($urandom));
      round_trip(t % 2, pl, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    sel = 0;
    @(negedge clk);
    start5 = 1;
    @(negedge clk);
    start5 = 0;
    bit_valid = 1;
    repeat (5) begin
      s_in = 1'($urandom);
      @(negedge clk);
    end
    bit_valid = 0;
    rst_n = 0;
    #1;
    chk("midrst_out", {out5, ov5, busy5, done5, ok5}, 0);
    exp_err5 = 0;
    exp_err16 = 0;
    check_err();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("midrst_idle", busy5, 0);
    chk("midrst_nodone", done5, 0);
    pl = {};
    for (int i = 0; i < N5; i++) pl.push_back(1'($urandom));
    round_trip(0, pl, 0, 0, 0, 0);
`ifdef CRC_ERR_CNT_EN
    for (int i = 0; i < N5; i++) pl[i] = 1'b0;
    full = pl;
    full.push_back(0); full.push_back(1); full.push_back(0); full.push_back(0); full.push_back(0);
    full[3] = 1'b1;
    repeat (300) run_pkt(0, 1, full, 0, 0, 0, 0, em, ok);
    chk("err_sat", err5, 8'hFF);
    check_err();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/crc_serial_engine.md
Name: crc_serial_engine

Overview:
- Parametrised serial CRC engine that generalises the fixed 5-bit token CRC unit.
- Width, polynomial, residual and payload length are parameters. Default configuration is USB CRC5; the CRC16 data-phase configuration is selected by parameter override.
- Two runtime modes:
  - Generate: computes the CRC over the payload, then shifts out the complemented CRC MSB-first under a ready handshake.
  - Check: consumes payload plus received CRC and flags a residual match.
- Sits between the USB bit-level serialiser/deserialiser and the packet FSMs.

Parameters:
- CRC_W, 5, CRC register width (2..32).
- POLY, 5'b00101, generator polynomial without the implicit x^CRC_W term.
- RESIDUAL, 5'b01100, expected register value after a good payload+CRC in check mode (CRC16 use: 16'h800D).
- DATA_LEN, 11, payload bits per packet (1..1023).

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- crc_start, input, 1, begin packet; sampled only in IDLE.
- mode, input, 1, 0 = generate, 1 = check; latched on accepted crc_start.
- s_in, input, 1, serial payload bit, MSB of stream first.
- bit_valid, input, 1, s_in valid this cycle.
- out_ready, input, 1, consumer accepts crc_out this cycle.
- crc_ack, input, 1, consumer acknowledges crc_done.
- crc_out, output, 1, current complemented CRC bit.
- crc_out_valid, output, 1, crc_out valid (EMIT state).
- busy, output, 1, not in IDLE.
- crc_done, output, 1, packet complete, held until crc_ack.
- crc_ok, output, 1, check-mode result, valid while crc_done.
- err_cnt, output, 8, present only with CRC_ERR_CNT_EN.

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE, CRC register all ones, bit counter 0, mode register 0.
  - All outputs 0.
- CRC update on each accepted bit:
  - fb = r[CRC_W-1] ^ s_in.
  - r <= {r[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
- Bit counter width is $clog2(DATA_LEN+CRC_W+1). It counts accepted bits only.
- IDLE:
  - crc_start=1: r <= all ones, counter <= 0, latch mode, go DATA next cycle.
  - bit_valid, out_ready and crc_ack are ignored.
- DATA:
  - Each cycle with bit_valid=1 updates r and increments the counter.
  - Generate mode: when the DATA_LEN-th bit is accepted, load the shift register with ~r_next and go EMIT.
  - Check mode: when bit DATA_LEN+CRC_W is accepted, register crc_ok = (r_next == RESIDUAL) and go DONE.
  - crc_start is ignored while busy.
- EMIT (generate only):
  - crc_out_valid=1 and crc_out = shift register MSB.
  - Each out_ready=1 shifts left by one and increments an emit count.
  - After the CRC_W-th accepted bit go DONE, with crc_out_valid=0 next cycle.
  - First crc_out_valid is asserted the cycle after the last payload bit is accepted (1-cycle latency).
  - out_ready=0 holds the bit stable indefinitely.
- DONE:
  - crc_done=1; crc_ok holds its value (0 in generate mode).
  - crc_ack=1: go IDLE and clear crc_done and crc_ok next cycle.
  - crc_start in the same cycle as crc_ack is ignored; a new packet needs crc_start in IDLE.
- Boundary conditions:
  - bit_valid in EMIT/DONE is ignored.
  - out_ready outside EMIT is ignored.
  - A reset mid-packet aborts to IDLE with no crc_done pulse.
  - DATA_LEN=1 is legal: first payload bit goes straight to EMIT or continues into CRC bits.
  - busy = (state != IDLE), registered.

Optional Feature:
- Macro CRC_ERR_CNT_EN.
- When defined:
  - err_cnt port exists: an 8-bit counter incremented on each check-mode entry to DONE with crc_ok=0.
  - It saturates at 8'hFF and is cleared only by reset.
- When undefined:
  - err_cnt port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Generate, defaults, mode=0, 11 zero bits, out_ready=1 -> crc_out 0,1,0,0,0 over 5 cycles, then crc_done=1, crc_ok=0; crc_ack -> IDLE.
- Check, defaults, mode=1, 11 zeros then 0,1,0,0,0 -> crc_done=1, crc_ok=1 (register 5'b01100).
- Check with payload bit 3 flipped, same CRC bits -> crc_ok=0; with CRC_ERR_CNT_EN, err_cnt 0->1. Repeat 300 times -> err_cnt saturates at 8'hFF.
- Backpressure/gaps: random bit_valid gaps in DATA and out_ready low 4 cycles mid-EMIT -> same crc_out sequence, crc_out stable while out_ready=0, no extra bits.
- CRC16 override (CRC_W=16, POLY=16'h8005, RESIDUAL=16'h800D, DATA_LEN=16):
  - Generate on 16'hA5C3, then feed payload+emitted CRC back in check mode -> crc_ok=1.
  - Same check with one bit corrupted -> crc_ok=0.
- Control edges:
  - crc_start while busy -> ignored, count unaffected.
  - rst_n low mid-DATA -> all outputs 0 immediately, IDLE.
  - crc_ack with crc_start in DONE -> IDLE, busy=0 next cycle.
